// File: rtl/riscy_pkg.sv
// -----------------------------------------------------------------------------
// riscy_pkg
// Shared definitions for the register-file write-back path.
//   XLEN        : datapath width
//   REG_ADDR_W  : register address width (32 architectural registers)
//   wb_entry_t  : one queued retire result {rd, data}
// -----------------------------------------------------------------------------
package riscy_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_if.sv
// -----------------------------------------------------------------------------
// regfile_writeback_if
// Retire-result channels from the LSU and the ALU into the write-back
// sequencer.
//   lsu_valid/lsu_rd/lsu_data, lsu_ready : LSU result channel
//   alu_valid/alu_rd/alu_data, alu_ready : ALU result channel
// Modports: master = result producers, slave = write-back sequencer.
//
// Handshake: a result transfers on a rising clock edge where valid and ready
// are both high. The producer holds rd/data stable while valid is high and
// ready is low. Ready never depends on the same channel's valid.
// -----------------------------------------------------------------------------
interface regfile_writeback_if #(
  parameter int XLEN = riscy_pkg::XLEN
);
  logic            lsu_valid;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;

  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;

  modport master (
    output lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready,
    output alu_valid, alu_rd, alu_data,
    input  alu_ready
  );

  modport slave (
    input  lsu_valid, lsu_rd, lsu_data,
    output lsu_ready,
    input  alu_valid, alu_rd, alu_data,
    output alu_ready
  );
endinterface

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Two-write / one-read circular buffer of wb_entry_t. Write port 0 is always
// the older of two same-cycle writes; port 1 is only used together with
// port 0. The whole entry array, its valid mask and the read pointer are
// exposed so the parent can search pending writes by age.
//   clk, rst            : clock, synchronous active-high reset
//   wr0_en_i/wr0_entry_i: first (older) write
//   wr1_en_i/wr1_entry_i: second (younger) write, only with wr0_en_i
//   pop_i               : remove head (caller guarantees not empty)
//   head_o, empty_o     : oldest entry, queue empty
//   count_o             : number of stored entries
//   entries_o, vld_o    : raw storage and per-slot valid mask
//   rd_ptr_o            : slot index of the head
// -----------------------------------------------------------------------------
module wb_fifo
  import riscy_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr0_en_i,
  input  wb_entry_t        wr0_entry_i,
  input  logic             wr1_en_i,
  input  wb_entry_t        wr1_entry_i,
  input  logic             pop_i,
  output wb_entry_t        head_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o,
  output wb_entry_t        entries_o [DEPTH],
  output logic [DEPTH-1:0] vld_o,
  output logic [PW-1:0]    rd_ptr_o
);

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wr_ptr_nx;

  assign wr_ptr_nx = wr_ptr_q + PW'(1);

  always_comb begin
    mem_d    = mem_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    // Pop is applied first; pushes never target the head slot because the
    // parent only grants a push when a free slot exists before the pop.
    if (pop_i) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PW'(1);
    end
    if (wr0_en_i) begin
      mem_d[wr_ptr_q] = wr0_entry_i;
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_nx;
    end
    if (wr0_en_i && wr1_en_i) begin
      mem_d[wr_ptr_nx] = wr1_entry_i;
      vld_d[wr_ptr_nx] = 1'b1;
      wr_ptr_d         = wr_ptr_q + PW'(2);
    end
    count_d = count_q + CW'(wr0_en_i) + CW'(wr0_en_i && wr1_en_i) - CW'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; the valid mask qualifies every slot.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_o    = mem_q[rd_ptr_q];
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign entries_o = mem_q;
  assign vld_o     = vld_q;
  assign rd_ptr_o  = rd_ptr_q;

endmodule

// File: rtl/regfile_writeback.sv
// -----------------------------------------------------------------------------
// regfile_writeback
// Write-side sequencer for the 32x32 register file. Accepts LSU and ALU
// retire results, queues them in order (LSU older on a tie), drains one
// entry per cycle onto the write port and flags pending writes to the two
// decode read addresses.
//   clk, rst              : clock, synchronous active-high reset
//   rif (slave)           : LSU/ALU result channels
//   we3, a3, wd3          : register file write port
//   q1, q2                : decode read addresses
//   busy1, busy2          : a queued write targets q1/q2
//   fwd1_hit/fwd1_data,
//   fwd2_hit/fwd2_data    : forwarding of the youngest queued value
//   empty                 : queue empty
// Build option: RF_WB_BYPASS_EN enables the forwarding outputs; without it
// they are tied to zero and the port list is unchanged.
// Parameter XLEN must equal riscy_pkg::XLEN, since entries use wb_entry_t.
// -----------------------------------------------------------------------------
module regfile_writeback #(
  parameter int DEPTH = 4,
  parameter int XLEN  = riscy_pkg::XLEN
) (
  input  logic                    clk,
  input  logic                    rst,
  regfile_writeback_if.slave      rif,
  output logic                    we3,
  output logic [4:0]              a3,
  output logic [XLEN-1:0]         wd3,
  input  logic [4:0]              q1,
  input  logic [4:0]              q2,
  output logic                    busy1,
  output logic                    busy2,
  output logic                    fwd1_hit,
  output logic                    fwd2_hit,
  output logic [XLEN-1:0]         fwd1_data,
  output logic [XLEN-1:0]         fwd2_data,
  output logic                    empty
);
  import riscy_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t        head;
  wb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             fifo_empty;
  logic [CW:0]      count_ext;
  logic             lsu_hs, alu_hs;
  logic             lsu_push, alu_push;
  wb_entry_t        lsu_entry, alu_entry;
  wb_entry_t        wr0_entry;

  // Space is judged on the registered count only, so ready has no path from
  // the same-cycle pop; this costs one entry of headroom.
  assign count_ext     = {1'b0, count};
  assign rif.lsu_ready = !rst && (count_ext <= (CW+1)'(DEPTH - 1));
  assign lsu_hs        = rif.lsu_valid && rif.lsu_ready;
  assign rif.alu_ready = !rst && ((count_ext + (CW+1)'(lsu_hs)) <= (CW+1)'(DEPTH - 1));
  assign alu_hs        = rif.alu_valid && rif.alu_ready;

  // x0 results complete the handshake but are dropped.
  assign lsu_push  = lsu_hs && (rif.lsu_rd != 5'd0);
  assign alu_push  = alu_hs && (rif.alu_rd != 5'd0);
  assign lsu_entry = '{rd: rif.lsu_rd, data: rif.lsu_data};
  assign alu_entry = '{rd: rif.alu_rd, data: rif.alu_data};
  assign wr0_entry = lsu_push ? lsu_entry : alu_entry;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr0_en_i   (lsu_push || alu_push),
    .wr0_entry_i(wr0_entry),
    .wr1_en_i   (lsu_push && alu_push),
    .wr1_entry_i(alu_entry),
    .pop_i      (we3),
    .head_o     (head),
    .empty_o    (fifo_empty),
    .count_o    (count),
    .entries_o  (entries),
    .vld_o      (vld),
    .rd_ptr_o   (rd_ptr)
  );

  // Drain: head goes out every cycle the queue is non-empty.
  assign empty = rst || fifo_empty;
  assign we3   = !empty;
  assign a3    = we3 ? head.rd   : 5'd0;
  assign wd3   = we3 ? head.data : '0;

  // Busy looks at stored entries only, never at this cycle's incoming results.
  always_comb begin
    busy1 = 1'b0;
    busy2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (entries[i].rd == q1)) busy1 = 1'b1;
      if (vld[i] && (entries[i].rd == q2)) busy2 = 1'b1;
    end
    if (rst || (q1 == 5'd0)) busy1 = 1'b0;
    if (rst || (q2 == 5'd0)) busy2 = 1'b0;
  end

`ifdef RF_WB_BYPASS_EN
  logic [PW-1:0] age_idx;

  // Walk from head (oldest) to tail; later matches overwrite earlier ones so
  // the youngest pending value wins.
  always_comb begin
    fwd1_data = '0;
    fwd2_data = '0;
    age_idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      age_idx = rd_ptr + PW'(k);
      if (vld[age_idx] && (entries[age_idx].rd == q1)) fwd1_data = entries[age_idx].data;
      if (vld[age_idx] && (entries[age_idx].rd == q2)) fwd2_data = entries[age_idx].data;
    end
    if (!busy1) fwd1_data = '0;
    if (!busy2) fwd2_data = '0;
  end

  assign fwd1_hit = busy1;
  assign fwd2_hit = busy2;
`else
  logic unused_bypass;

  always_comb begin
    unused_bypass = ^rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      unused_bypass = unused_bypass ^ (^entries[i].data);
    end
  end

  assign fwd1_hit  = 1'b0;
  assign fwd2_hit  = 1'b0;
  assign fwd1_data = '0;
  assign fwd2_data = '0;
`endif

endmodule
